// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control stage.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int unsigned TICK_DIV_DEFAULT = 500000;
  localparam int unsigned MOD_CS           = 100;
  localparam int unsigned MOD_SM           = 60;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit_pair.sv
// Two-digit BCD counter (00..MODULUS-1) with synchronous clear and carry-out.
module bcd_digit_pair
  import stopwatch_pkg::*;
#(
  parameter int unsigned MODULUS = MOD_CS
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       EN,
  input  logic       CLR,
  output logic [3:0] TENS,
  output logic [3:0] UNITS,
  output logic       CO
);

  localparam bcd_t TENS_MAX = bcd_t'(MODULUS / 10 - 1);

  // Carry is combinational so a whole cascade advances on the same edge.
  assign CO = EN && (TENS == TENS_MAX) && (UNITS == 4'd9);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      TENS  <= '0;
      UNITS <= '0;
    end else if (CLR) begin
      TENS  <= '0;
      UNITS <= '0;
    end else if (EN) begin
      if (UNITS == 4'd9) begin
        UNITS <= '0;
        TENS  <= (TENS == TENS_MAX) ? '0 : TENS + 4'd1;
      end else begin
        UNITS <= UNITS + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: start/stop/lap/clear FSM, centisecond prescaler,
// MM:SS.cc BCD time counter, frozen-on-lap display register and status LEDs.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       START_SIG,
  input  logic       LAP_SIG,
  output logic [3:0] DISP_M10,
  output logic [3:0] DISP_M1,
  output logic [3:0] DISP_S10,
  output logic [3:0] DISP_S1,
  output logic [3:0] DISP_C10,
  output logic [3:0] DISP_C1,
  output logic       RUN_LED,
  output logic       LAP_LED
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic          running, tick, lap_req, clr, freeze;
  logic          cs_carry, sec_carry, min_carry_unused;
  logic [3:0]    cs_t, cs_u, sec_t, sec_u, min_t, min_u;

  assign running = (state == RUN) || (state == LAP);
  assign tick    = running && (presc == PMAX);
  assign lap_req = LAP_SIG && !START_SIG;
  assign clr     = (state == IDLE) || ((state == STOP) && lap_req);
  // Hold the display on the edge entering LAP and while LAP persists;
  // any pulse that leaves LAP reloads the live count on that same edge.
  assign freeze  = ((state == RUN) && lap_req) ||
                   ((state == LAP) && !START_SIG && !LAP_SIG);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= IDLE;
      RUN_LED <= 1'b0;
      LAP_LED <= 1'b0;
    end else begin
      case (state)
        IDLE: if (START_SIG) begin
          state   <= RUN;
          RUN_LED <= 1'b1;
        end
        RUN: if (START_SIG) begin
          state   <= STOP;
          RUN_LED <= 1'b0;
        end else if (lap_req) begin
          state   <= LAP;
          LAP_LED <= 1'b1;
        end
        LAP: if (START_SIG) begin
          state   <= STOP;
          RUN_LED <= 1'b0;
          LAP_LED <= 1'b0;
        end else if (lap_req) begin
          state   <= RUN;
          LAP_LED <= 1'b0;
        end
        STOP: if (START_SIG) begin
          state   <= RUN;
          RUN_LED <= 1'b1;
        end else if (lap_req) begin
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          RUN_LED <= 1'b0;
          LAP_LED <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (running) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  bcd_digit_pair #(.MODULUS(MOD_CS)) u_cs (
    .CLK(CLK), .RSTN(RSTN), .EN(tick), .CLR(clr),
    .TENS(cs_t), .UNITS(cs_u), .CO(cs_carry)
  );

  bcd_digit_pair #(.MODULUS(MOD_SM)) u_sec (
    .CLK(CLK), .RSTN(RSTN), .EN(cs_carry), .CLR(clr),
    .TENS(sec_t), .UNITS(sec_u), .CO(sec_carry)
  );

  bcd_digit_pair #(.MODULUS(MOD_SM)) u_min (
    .CLK(CLK), .RSTN(RSTN), .EN(sec_carry), .CLR(clr),
    .TENS(min_t), .UNITS(min_u), .CO(min_carry_unused)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      {DISP_M10, DISP_M1, DISP_S10, DISP_S1, DISP_C10, DISP_C1} <= '0;
    end else if (!freeze) begin
      {DISP_M10, DISP_M1, DISP_S10, DISP_S1, DISP_C10, DISP_C1} <=
        {min_t, min_u, sec_t, sec_u, cs_t, cs_u};
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed + randomized bench for stopwatch_ctrl against a centisecond-count model.
module tb_stopwatch_ctrl;

  localparam int TD      = 4;
  localparam int WRAP_CS = 360000;

  logic CLK, RSTN, START_SIG, LAP_SIG;
  logic [3:0] DISP_M10, DISP_M1, DISP_S10, DISP_S1, DISP_C10, DISP_C1;
  logic RUN_LED, LAP_LED;
  logic [23:0] disp_obs;

  assign disp_obs = {DISP_M10, DISP_M1, DISP_S10, DISP_S1, DISP_C10, DISP_C1};

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .CLK(CLK), .RSTN(RSTN), .START_SIG(START_SIG), .LAP_SIG(LAP_SIG),
    .DISP_M10(DISP_M10), .DISP_M1(DISP_M1), .DISP_S10(DISP_S10),
    .DISP_S1(DISP_S1), .DISP_C10(DISP_C10), .DISP_C1(DISP_C1),
    .RUN_LED(RUN_LED), .LAP_LED(LAP_LED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef enum {M_IDLE, M_RUN, M_LAP, M_STOP} mstate_t;

  mstate_t m_st;
  int      m_p, m_t, m_disp;
  int      checks, fails;
  string   phase;

  function automatic logic [23:0] to_bcd(input int cs);
    int m, s, c;
    m = cs / 6000;
    s = (cs / 100) % 60;
    c = cs % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_p = 0; m_t = 0; m_disp = 0;
  endtask

  // One clock edge of the stopwatch, in terms of elapsed centiseconds.
  task automatic model_step(input bit s, input bit l);
    mstate_t nxt;
    int      t_before;
    bit      lap;
    lap      = l && !s;
    t_before = m_t;
    nxt      = m_st;
    case (m_st)
      M_IDLE: if (s) nxt = M_RUN;
      M_RUN:  if (s) nxt = M_STOP; else if (lap) nxt = M_LAP;
      M_LAP:  if (s) nxt = M_STOP; else if (lap) nxt = M_RUN;
      M_STOP: if (s) nxt = M_RUN;  else if (lap) nxt = M_IDLE;
    endcase
    if (m_st == M_RUN || m_st == M_LAP) begin
      if (m_p == TD - 1) begin
        m_p = 0;
        m_t = (m_t + 1) % WRAP_CS;
      end else begin
        m_p++;
      end
    end
    if (m_st == M_IDLE || (m_st == M_STOP && lap)) begin
      m_t = 0;
      m_p = 0;
    end
    if (nxt != M_LAP) m_disp = t_before;
    m_st = nxt;
  endtask

  task automatic check_model();
    chk("disp", 32'(disp_obs), 32'(to_bcd(m_disp)));
    chk("run_led", 32'(RUN_LED), 32'(m_st == M_RUN || m_st == M_LAP));
    chk("lap_led", 32'(LAP_LED), 32'(m_st == M_LAP));
  endtask

  task automatic cycle(input bit s, input bit l);
    START_SIG = s;
    LAP_SIG   = l;
    @(posedge CLK);
    model_step(s, l);
    #1;
    START_SIG = 1'b0;
    LAP_SIG   = 1'b0;
    check_model();
  endtask

  task automatic run_until_disp(input int target, input int budget);
    int n;
    n = 0;
    while (m_disp != target && n < budget) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    chk("reach_target", 32'(m_disp == target), 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_disp"}, 32'(disp_obs), 32'd0);
    chk({tag, "_run"}, 32'(RUN_LED), 32'd0);
    chk({tag, "_lap"}, 32'(LAP_LED), 32'd0);
  endtask

  initial begin
    logic [23:0] held;
    int          n;
    checks = 0;
    fails  = 0;
    RSTN = 1'b0; START_SIG = 1'b0; LAP_SIG = 1'b0;
    model_reset();

    phase = "reset";
    #2;
    check_zero_outputs("rst");
    #20 RSTN = 1'b1;
    repeat (3) cycle(1'b0, 1'b0);

    phase = "start";
    cycle(1'b1, 1'b0);
    chk("run_led_next", 32'(RUN_LED), 32'd1);
    repeat (4) cycle(1'b0, 1'b0);
    chk("c1_before", 32'(DISP_C1), 32'd0);
    cycle(1'b0, 1'b0);
    chk("c1_at_5", 32'(DISP_C1), 32'd1);
    repeat (36) cycle(1'b0, 1'b0);
    chk("disp_0010", 32'(disp_obs), 32'h000010);

    phase = "sec_carry";
    run_until_disp(99, 400);
    run_until_disp(100, 8);
    chk("disp_0100", 32'(disp_obs), 32'h000100);

    phase = "stop_resume";
    n = 0;
    while (m_p != 1 && n < 8) begin cycle(1'b0, 1'b0); n++; end
    cycle(1'b1, 1'b0);
    chk("presc_held", 32'(m_p), 32'd2);
    cycle(1'b0, 1'b0);
    held = disp_obs;
    repeat (100) cycle(1'b0, 1'b0);
    chk("stop_hold", 32'(disp_obs), 32'(held));
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("no_tick_yet", 32'(disp_obs), 32'(held));
    cycle(1'b0, 1'b0);
    chk("tick_after_2", 32'(disp_obs), 32'(to_bcd(m_t)));
    chk("tick_value", 32'(m_disp), 32'(m_t));

    phase = "lap";
    run_until_disp(123, 200);
    cycle(1'b0, 1'b1);
    chk("lap_frozen", 32'(disp_obs), 32'h000123);
    chk("lap_led_on", 32'(LAP_LED), 32'd1);
    repeat (20) cycle(1'b0, 1'b0);
    chk("lap_still", 32'(disp_obs), 32'h000123);
    chk("count_moved", 32'(m_t > 123), 32'd1);
    cycle(1'b0, 1'b1);
    chk("lap_released", 32'(disp_obs), 32'(to_bcd(m_disp)));
    chk("lap_led_off", 32'(LAP_LED), 32'd0);

    phase = "clear";
    repeat (5) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    check_zero_outputs("cleared");
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    check_zero_outputs("lap_in_idle");
    cycle(1'b1, 1'b0);
    repeat (9) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    chk("both_to_stop_run", 32'(RUN_LED), 32'd0);
    chk("both_to_stop_lap", 32'(LAP_LED), 32'd0);

    phase = "hour_wrap";
    force dut.u_min.TENS  = 4'd5;
    force dut.u_min.UNITS = 4'd9;
    force dut.u_sec.TENS  = 4'd5;
    force dut.u_sec.UNITS = 4'd9;
    force dut.u_cs.TENS   = 4'd9;
    force dut.u_cs.UNITS  = 4'd9;
    #1;
    release dut.u_min.TENS;
    release dut.u_min.UNITS;
    release dut.u_sec.TENS;
    release dut.u_sec.UNITS;
    release dut.u_cs.TENS;
    release dut.u_cs.UNITS;
    m_t = WRAP_CS - 1;
    cycle(1'b0, 1'b0);
    chk("disp_595999", 32'(disp_obs), 32'h595999);
    cycle(1'b1, 1'b0);
    run_until_disp(0, 10);
    chk("wrap_zero", 32'(disp_obs), 32'd0);
    chk("wrap_run_led", 32'(RUN_LED), 32'd1);
    repeat (8) cycle(1'b0, 1'b0);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end

    phase = "async_reset";
    #2 RSTN = 1'b0;
    model_reset();
    #1 check_zero_outputs("pre");
    #4 RSTN = 1'b1;
    cycle(1'b1, 1'b0);
    run_until_disp(1234, 6000);
    chk("disp_1234", 32'(disp_obs), 32'h001234);
    #2 RSTN = 1'b0;
    model_reset();
    #1 check_zero_outputs("async");
    @(posedge CLK);
    #3 RSTN = 1'b1;
    repeat (12) cycle(1'b0, 1'b0);
    check_zero_outputs("no_count");
    cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    chk("restart_disp", 32'(disp_obs), 32'h000001);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
